// File: rtl/miriscv_pkg.sv
// Shared types and constants for the MIRISCV data-side bus bridge.
//   bus_state_e    : APB master phase (idle / setup / access)
//   APB_REGION_BIT : address bit that selects the APB region when set
//   slot_width()   : width of the APB slot index, never narrower than one bit
package miriscv_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_SETUP  = 2'd1,
        BUS_ACCESS = 2'd2
    } bus_state_e;

    localparam int unsigned APB_REGION_BIT = 31;

    function automatic int unsigned slot_width(input int unsigned n_slots);
        return (n_slots > 1) ? $clog2(n_slots) : 1;
    endfunction

endpackage

// File: rtl/miriscv_apb_master.sv
// Two-phase APB master for one transfer at a time, with PREADY wait states
// and an ACCESS-phase timeout.
//   clk, rst_n           : clock, async active-low reset
//   start                : launch a transfer (honoured only while idle)
//   slot/we/be/addr/wdata: transfer attributes captured on start
//   idle_c               : master is idle and can accept start (combinational)
//   done_c               : transfer ends this cycle (combinational)
//   rsp_rdata_c/rsp_err_c: response for the ending transfer (combinational)
//   psel..pstrb          : registered APB request signals
//   prdata/pready/pslverr: per-slot APB responses
module miriscv_apb_master
    import miriscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned N_APB   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned SLOT_W  = slot_width(N_APB)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SLOT_W-1:0]     slot,
    input  logic                  we,
    input  logic [XLEN/8-1:0]     be,
    input  logic [XLEN-1:0]       addr,
    input  logic [XLEN-1:0]       wdata,
    output logic                  idle_c,
    output logic                  done_c,
    output logic [XLEN-1:0]       rsp_rdata_c,
    output logic                  rsp_err_c,
    output logic [N_APB-1:0]      psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [XLEN-1:0]       paddr,
    output logic [XLEN-1:0]       pwdata,
    output logic [XLEN/8-1:0]     pstrb,
    input  logic [N_APB*XLEN-1:0] prdata,
    input  logic [N_APB-1:0]      pready,
    input  logic [N_APB-1:0]      pslverr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    bus_state_e         state;
    logic [SLOT_W-1:0]  slot_q;
    logic [CNT_W-1:0]   cnt;
    logic [N_APB-1:0]   slot_onehot;
    logic               sel_ready;
    logic               sel_err;
    logic [XLEN-1:0]    sel_rdata;
    logic               expired;

    // One-hot select for the incoming slot index.
    always_comb begin
        slot_onehot = '0;
        for (int unsigned k = 0; k < N_APB; k++) begin
            if (slot == SLOT_W'(k)) begin
                slot_onehot[k] = 1'b1;
            end
        end
    end

    // Response signals of the slot owning the current transfer.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < N_APB; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                sel_ready = pready[k];
                sel_err   = pslverr[k];
                sel_rdata = prdata[k*XLEN +: XLEN];
            end
        end
    end

    // The ACCESS cycle that would push the count to TIMEOUT is the last one.
    assign expired     = (cnt == CNT_W'(TIMEOUT - 1));
    assign idle_c      = (state == BUS_IDLE);
    assign done_c      = (state == BUS_ACCESS) && (sel_ready || expired);
    assign rsp_err_c   = sel_ready ? sel_err : 1'b1;
    assign rsp_rdata_c = (sel_ready && !pwrite) ? sel_rdata : '0;

    // Transfer sequencing; pready takes priority over an expiring timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BUS_IDLE;
            slot_q  <= '0;
            cnt     <= '0;
            psel    <= '0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (start) begin
                        state  <= BUS_SETUP;
                        slot_q <= slot;
                        psel   <= slot_onehot;
                        pwrite <= we;
                        paddr  <= addr;
                        pwdata <= wdata;
                        pstrb  <= be;
                    end
                end
                BUS_SETUP: begin
                    state   <= BUS_ACCESS;
                    penable <= 1'b1;
                    cnt     <= '0;
                end
                BUS_ACCESS: begin
                    if (sel_ready || expired) begin
                        state   <= BUS_IDLE;
                        psel    <= '0;
                        penable <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= BUS_IDLE;
                    psel    <= '0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/miriscv_data_bus_bridge.sv
// Data-side interconnect between the core LSU and the SoC. Routes each core
// request to on-chip RAM (addr[31]=0) or to an APB slave slot (addr[31]=1),
// and returns exactly one in-order response pulse per accepted request.
//   clk_i, arstn_i      : clock, async active-low reset
//   data_*              : core LSU request/response channel
//   mem_*               : on-chip RAM port (request pass-through, 1-cycle read data)
//   psel_o..pstrb_o     : APB request signals
//   prdata_i/pready_i/pslverr_i : per-slot APB responses
module miriscv_data_bus_bridge
    import miriscv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned N_APB      = 4,
    parameter int unsigned SLOT_SHIFT = 12,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [XLEN/8-1:0]     data_be_i,
    input  logic [XLEN-1:0]       data_addr_i,
    input  logic [XLEN-1:0]       data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [XLEN-1:0]       data_rdata_o,
    output logic                  data_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [XLEN/8-1:0]     mem_be_o,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic [XLEN-1:0]       mem_rdata_i,
    output logic [N_APB-1:0]      psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [XLEN-1:0]       paddr_o,
    output logic [XLEN-1:0]       pwdata_o,
    output logic [XLEN/8-1:0]     pstrb_o,
    input  logic [N_APB*XLEN-1:0] prdata_i,
    input  logic [N_APB-1:0]      pready_i,
    input  logic [N_APB-1:0]      pslverr_i
);

    localparam int unsigned SLOT_W  = slot_width(N_APB);
    localparam int unsigned FIELD_W = APB_REGION_BIT - SLOT_SHIFT;

    logic               apb_idle_c;
    logic               apb_done_c;
    logic               apb_err_c;
    logic [XLEN-1:0]    apb_rdata_c;
    logic [FIELD_W-1:0] region_field;
    logic [SLOT_W-1:0]  slot_idx;
    logic               is_apb;
    logic               is_mapped;
    logic               accept;
    logic               ram_acc;
    logic               apb_start;
    logic               unmapped_acc;
    logic               ram_rsp_q;
    logic [XLEN-1:0]    rdata_q;

    // Address decode: every bit between the slot shift and the region bit
    // takes part, so addresses beyond the last slot are reported as unmapped.
    assign is_apb       = data_addr_i[APB_REGION_BIT];
    assign region_field = data_addr_i[APB_REGION_BIT-1:SLOT_SHIFT];
    assign is_mapped    = (region_field < FIELD_W'(N_APB));
    assign slot_idx     = region_field[SLOT_W-1:0];

    assign data_gnt_o   = apb_idle_c;
    assign accept       = data_req_i && apb_idle_c;
    assign ram_acc      = accept && !is_apb;
    assign apb_start    = accept && is_apb && is_mapped;
    assign unmapped_acc = accept && is_apb && !is_mapped;

    // RAM request is a straight pass-through of the core request.
    assign mem_req_o   = ram_acc;
    assign mem_we_o    = data_we_i;
    assign mem_be_o    = data_be_i;
    assign mem_addr_o  = data_addr_i;
    assign mem_wdata_o = data_wdata_i;

    miriscv_apb_master #(
        .XLEN    (XLEN),
        .N_APB   (N_APB),
        .TIMEOUT (TIMEOUT),
        .SLOT_W  (SLOT_W)
    ) u_apb_master (
        .clk         (clk_i),
        .rst_n       (arstn_i),
        .start       (apb_start),
        .slot        (slot_idx),
        .we          (data_we_i),
        .be          (data_be_i),
        .addr        (data_addr_i),
        .wdata       (data_wdata_i),
        .idle_c      (apb_idle_c),
        .done_c      (apb_done_c),
        .rsp_rdata_c (apb_rdata_c),
        .rsp_err_c   (apb_err_c),
        .psel        (psel_o),
        .penable     (penable_o),
        .pwrite      (pwrite_o),
        .paddr       (paddr_o),
        .pwdata      (pwdata_o),
        .pstrb       (pstrb_o),
        .prdata      (prdata_i),
        .pready      (pready_i),
        .pslverr     (pslverr_i)
    );

    // Response register. RAM accepts and APB completions are mutually
    // exclusive because accepts only happen while the APB master is idle.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            ram_rsp_q     <= 1'b0;
            rdata_q       <= '0;
        end else begin
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            ram_rsp_q     <= 1'b0;
            if (ram_acc) begin
                data_rvalid_o <= 1'b1;
                ram_rsp_q     <= !data_we_i;
                rdata_q       <= '0;
            end else if (unmapped_acc) begin
                data_rvalid_o <= 1'b1;
                data_err_o    <= 1'b1;
                rdata_q       <= '0;
            end else if (apb_done_c) begin
                data_rvalid_o <= 1'b1;
                data_err_o    <= apb_err_c;
                rdata_q       <= apb_rdata_c;
            end
        end
    end

    // RAM read data arrives one cycle after the request, alongside rvalid.
    assign data_rdata_o = ram_rsp_q ? mem_rdata_i : rdata_q;

endmodule
